bht_trace_driver: RTL and testbench

Hardware trace player that drives a branch-history-table predictor from a stored branch trace. It streams (pc, taken) records from an internal trace RAM to the predictor, holds each record for a fixed prediction latency, and samples the prediction. It strobes a single training update per record and accumulates total and correct prediction counts. It sits on the predictor's input side as the synthesizable counterpart of the file-driven stimulus, so predictor accuracy can be measured on-chip or in gate-level simulation.

---
 rtl/bht_pkg.sv | 23 ++
 rtl/bht_trace_ram.sv | 38 +++
 rtl/bht_trace_driver.sv | 174 +++++++++++++++++
 tb/tb_bht_trace_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared types for the branch-history-table trace player.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bht_pkg;

    // Default PC width driven to the predictor.
    localparam int BHT_PC_W = 9;

    // One stored trace record, laid out as {taken, pc} in trace RAM.
    typedef struct packed {
        logic                taken;
        logic [BHT_PC_W-1:0] pc;
    } trace_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_SCORE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/bht_trace_ram.sv
// Trace record store: DEPTH x W, one write port, one read port.
// Latency: write lands at the clock edge; read data valid one cycle after i_rd_en.
// Backpressure: none; the caller gates writes (dropped while a run is busy).
//
// Ports:
//   i_clk                         clock
//   i_wr_en / i_wr_addr / i_wr_data  synchronous write port
//   i_rd_en / i_rd_addr           read request; o_rd_data holds until next read
module bht_trace_ram #(
    parameter  int DEPTH = 256,
    parameter  int W     = 10,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rd_data;

    // Contents are deliberately left unreset so this maps onto a RAM macro.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bht_trace_driver.sv
// Trace player: streams {pc, taken} records to a branch predictor and scores its predictions.
// Latency: PRED_LAT+2 cycles per record (FETCH, PRED_LAT x HOLD, SCORE); done N*(PRED_LAT+2) cycles after start.
// Backpressure: none; start is ignored while busy and trace writes are dropped while busy.
//
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_trace_wr_*                trace RAM load port (IDLE/DONE only)
//   i_num_records, i_start      run length (clamped to DEPTH) and run request pulse
//   i_prediction                predictor output for o_pc
//   o_pc, o_taken, o_update_en  record presented to the predictor and training strobe
//   o_busy, o_done              run status
//   o_mispredict                pulse the cycle after a wrong prediction is scored
//   o_total_cnt, o_correct_cnt  accuracy counters
module bht_trace_driver
    import bht_pkg::*;
#(
    parameter  int DEPTH    = 256,
    parameter  int PC_W     = BHT_PC_W,
    parameter  int PRED_LAT = 2,
    parameter  int CNT_W    = $clog2(DEPTH) + 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_trace_wr_en,
    input  logic [AW-1:0]    i_trace_wr_addr,
    input  logic [PC_W:0]    i_trace_wr_data,
    input  logic [CNT_W-1:0] i_num_records,
    input  logic             i_start,
    input  logic             i_prediction,
    output logic [PC_W-1:0]  o_pc,
    output logic             o_taken,
    output logic             o_update_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_mispredict,
    output logic [CNT_W-1:0] o_total_cnt,
    output logic [CNT_W-1:0] o_correct_cnt
);

    localparam int HC_W = (PRED_LAT > 1) ? $clog2(PRED_LAT) : 1;

    state_e           r_state, w_next;
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    r_last_idx;
    logic [HC_W-1:0]  r_hold;
    logic [PC_W-1:0]  r_pc;
    logic             r_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_total, r_correct;

    logic             w_start_ok;
    logic [CNT_W-1:0] w_clamped;
    logic             w_rd_en;
    logic [AW-1:0]    w_rd_addr;
    logic [PC_W:0]    w_rd_data;
    logic             w_busy;

    assign w_start_ok = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_clamped  = (i_num_records > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : i_num_records;

    // The RAM read is launched on the edge entering FETCH, so the record is
    // already on the read port during FETCH and is captured into o_pc/o_taken
    // at the FETCH->HOLD edge.
    bht_trace_ram #(
        .DEPTH (DEPTH),
        .W     (PC_W + 1)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (i_trace_wr_en && !w_busy),
        .i_wr_addr (i_trace_wr_addr),
        .i_wr_data (i_trace_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_next      = r_state;
        w_rd_en     = 1'b0;
        w_rd_addr   = r_idx;
        w_busy      = 1'b0;
        o_update_en = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                o_done = (r_state == ST_DONE);
                if (i_start) begin
                    if (i_num_records == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next    = ST_FETCH;
                        w_rd_en   = 1'b1;
                        w_rd_addr = '0;
                    end
                end
            end
            ST_FETCH: begin
                w_busy = 1'b1;
                w_next = ST_HOLD;
            end
            ST_HOLD: begin
                w_busy = 1'b1;
                if (r_hold == HC_W'(PRED_LAT - 1)) begin
                    w_next = ST_SCORE;
                end
            end
            ST_SCORE: begin
                w_busy      = 1'b1;
                o_update_en = 1'b1;
                if (r_idx == r_last_idx) begin
                    w_next = ST_DONE;
                end else begin
                    w_next    = ST_FETCH;
                    w_rd_en   = 1'b1;
                    w_rd_addr = r_idx + 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_last_idx   <= '0;
            r_hold       <= '0;
            r_pc         <= '0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_total      <= '0;
            r_correct    <= '0;
        end else begin
            r_state      <= w_next;
            r_mispredict <= 1'b0;
            if (w_start_ok) begin
                r_idx      <= '0;
                // Stored as count-1 so it fits the index width even at count == DEPTH.
                r_last_idx <= AW'(w_clamped - 1'b1);
                r_total    <= '0;
                r_correct  <= '0;
            end
            case (r_state)
                ST_FETCH: begin
                    r_pc    <= w_rd_data[PC_W-1:0];
                    r_taken <= w_rd_data[PC_W];
                    r_hold  <= '0;
                end
                ST_HOLD: begin
                    r_hold <= r_hold + 1'b1;
                end
                ST_SCORE: begin
                    r_total <= r_total + 1'b1;
                    if (i_prediction == r_taken) begin
                        r_correct <= r_correct + 1'b1;
                    end else begin
                        r_mispredict <= 1'b1;
                    end
                    r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_taken       = r_taken;
    assign o_busy        = w_busy;
    assign o_mispredict  = r_mispredict;
    assign o_total_cnt   = r_total;
    assign o_correct_cnt = r_correct;

endmodule

// File: tb/tb_bht_trace_driver.sv
// Scoreboard bench for bht_trace_driver: expected records/run results are queued
// by the stimulus and popped by a negedge monitor on o_update_en / o_done rising.
module tb_bht_trace_driver;
    import bht_pkg::*;

    localparam int DEPTH    = 256;
    localparam int PC_W     = BHT_PC_W;
    localparam int PRED_LAT = 2;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int AW       = $clog2(DEPTH);
    localparam int REC_CYC  = PRED_LAT + 2;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             wr_en     = 1'b0;
    logic [AW-1:0]    wr_addr   = '0;
    trace_rec_t       wr_data   = '0;
    logic [CNT_W-1:0] num       = '0;
    logic             start     = 1'b0;
    logic             pred_mode = 1'b1;   // 1: predictor follows taken, 0: constant not-taken
    logic             prediction;

    logic [PC_W-1:0]  o_pc;
    logic             o_taken, o_update_en, o_busy, o_done, o_mispredict;
    logic [CNT_W-1:0] o_total_cnt, o_correct_cnt;

    assign prediction = pred_mode ? o_taken : 1'b0;

    bht_trace_driver #(
        .DEPTH    (DEPTH),
        .PC_W     (PC_W),
        .PRED_LAT (PRED_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_trace_wr_en   (wr_en),
        .i_trace_wr_addr (wr_addr),
        .i_trace_wr_data (wr_data),
        .i_num_records   (num),
        .i_start         (start),
        .i_prediction    (prediction),
        .o_pc            (o_pc),
        .o_taken         (o_taken),
        .o_update_en     (o_update_en),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_mispredict    (o_mispredict),
        .o_total_cnt     (o_total_cnt),
        .o_correct_cnt   (o_correct_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic            mis;
    } rec_t;

    typedef struct {
        int   total;
        int   correct;
        int   upd;
        int   mis;
        int   lat;
        logic was_busy;
    } run_t;

    rec_t rec_q[$];
    run_t run_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int runs_done = 0;

    // Short reference trace used by most runs.
    logic [PC_W-1:0] tpc [4] = '{9'h010, 9'h010, 9'h020, 9'h010};
    logic            ttk [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic mis_pend = 1'b0, mis_exp = 1'b0;
    logic prev_done = 1'b0, prev_busy = 1'b0, prev_upd = 1'b0;
    int   run_start = 0, upd_cnt = 0, mis_cnt = 0;

    always @(negedge clk) begin
        rec_t r;
        run_t e;
        if (!rst_n) begin
            mis_pend  = 1'b0;
            prev_done = 1'b0;
            prev_busy = 1'b0;
            prev_upd  = 1'b0;
        end else begin
            if (mis_pend) begin
                chk("mispredict", o_mispredict, mis_exp);
                mis_pend = 1'b0;
            end else begin
                chk("mispredict_quiet", o_mispredict, 0);
            end
            if (o_mispredict) mis_cnt++;
            if (start && !o_busy) begin
                run_start = cyc;
                upd_cnt   = 0;
                mis_cnt   = 0;
            end
            if (o_update_en) begin
                chk("update_gap", prev_upd, 0);
                upd_cnt++;
                if (rec_q.size() == 0) begin
                    chk("unexpected_update_q", rec_q.size(), 1);
                end else begin
                    r = rec_q.pop_front();
                    chk("pc", o_pc, r.pc);
                    chk("taken", o_taken, r.taken);
                    mis_pend = 1'b1;
                    mis_exp  = r.mis;
                end
            end
            if (o_done && !prev_done) begin
                runs_done++;
                if (run_q.size() == 0) begin
                    chk("unexpected_done_q", run_q.size(), 1);
                end else begin
                    e = run_q.pop_front();
                    chk("total_cnt", o_total_cnt, e.total);
                    chk("correct_cnt", o_correct_cnt, e.correct);
                    chk("update_count", upd_cnt, e.upd);
                    chk("mispredict_count", mis_cnt, e.mis);
                    chk("done_latency", cyc - run_start, e.lat);
                    chk("busy_fall", {prev_busy, o_busy}, {e.was_busy, 1'b0});
                end
            end
            prev_done = o_done;
            prev_busy = o_busy;
            prev_upd  = o_update_en;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input int addr, input logic [PC_W-1:0] pc, input logic tk);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = '{taken: tk, pc: pc};
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic do_start(input int n);
        @(posedge clk); #1;
        num   = CNT_W'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_rec(input logic [PC_W-1:0] pc, input logic tk, input logic mis);
        rec_t r;
        r.pc = pc; r.taken = tk; r.mis = mis;
        rec_q.push_back(r);
    endtask

    task automatic push_run(input int total, input int correct, input int upd,
                            input int mis, input int lat, input logic was_busy);
        run_t e;
        e.total = total; e.correct = correct; e.upd = upd;
        e.mis = mis; e.lat = lat; e.was_busy = was_busy;
        run_q.push_back(e);
    endtask

    task automatic push_short(input logic const0);
        for (int i = 0; i < 4; i++) push_rec(tpc[i], ttk[i], const0 && ttk[i]);
        if (const0) push_run(4, 1, 4, 3, 4 * REC_CYC + 1, 1'b1);
        else        push_run(4, 4, 4, 0, 4 * REC_CYC + 1, 1'b1);
    endtask

    task automatic wait_run(input int target);
        int n = 0;
        while (runs_done < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("run_completed", runs_done >= target, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, o_pc, 0);
        chk({tag, "_taken"}, o_taken, 0);
        chk({tag, "_update_en"}, o_update_en, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_mispredict"}, o_mispredict, 0);
        chk({tag, "_total"}, o_total_cnt, 0);
        chk({tag, "_correct"}, o_correct_cnt, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        #1;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero-length run: done one cycle after start, nothing scored.
        push_run(0, 0, 0, 0, 1, 1'b0);
        do_start(0);
        wait_run(1);

        // Full RAM, request beyond DEPTH is clamped to DEPTH.
        for (int i = 0; i < DEPTH; i++) load(i, PC_W'((i * 37) & 511), i[0]);
        pred_mode = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_rec(PC_W'((i * 37) & 511), i[0], 1'b0);
        push_run(DEPTH, DEPTH, DEPTH, 0, DEPTH * REC_CYC + 1, 1'b1);
        do_start(300);
        wait_run(2);

        // Short trace, perfect predictor; start and RAM write while busy are ignored.
        for (int i = 0; i < 4; i++) load(i, tpc[i], ttk[i]);
        push_short(1'b0);
        do_start(4);
        repeat (5) @(posedge clk);
        #1;
        num     = CNT_W'(1);
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = '{taken: 1'b0, pc: 9'h1FF};
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        num   = CNT_W'(4);
        wait_run(3);

        // Back-to-back run from DONE; also reads RAM[0] back after the dropped write.
        push_short(1'b0);
        do_start(4);
        wait_run(4);

        // Constant not-taken predictor.
        pred_mode = 1'b0;
        push_short(1'b1);
        do_start(4);
        wait_run(5);

        // Reset in the HOLD phase of record 2, then a clean replay.
        pred_mode = 1'b1;
        push_rec(tpc[0], ttk[0], 1'b0);
        push_rec(tpc[1], ttk[1], 1'b0);
        do_start(4);
        repeat (9) @(posedge clk);
        #1;
        chk("pre_reset_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrun_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_short(1'b0);
        do_start(4);
        wait_run(6);

        repeat (3) @(posedge clk);
        chk("rec_queue_drained", rec_q.size(), 0);
        chk("run_queue_drained", run_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
